// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_pkg
// Description : Shared constants, FSM state type and volume-target helper
//               for the DAC feed controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dac_pkg;

    localparam int VOLUME_MAX = 80;
    localparam int SAMPLE_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_FETCH     = 2'd2
    } feed_state_t;

    // Mute forces silence; otherwise the request is clamped to the codec range.
    function automatic logic [7:0] ramp_target(input logic mute, input logic [7:0] req);
        if (mute) begin
            return 8'd0;
        end else if (req > 8'(VOLUME_MAX)) begin
            return 8'(VOLUME_MAX);
        end else begin
            return req;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_mix.sv
`default_nettype none
// ============================================================================
// Module      : sample_mix
// Description : Signed sum of two samples, saturated to the sample range.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_mix
    import dac_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [SAMPLE_W-1:0] b,
    output logic signed [SAMPLE_W-1:0] sum
);

    localparam logic [SAMPLE_W-1:0] c_pos_max = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] c_neg_min = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic signed [SAMPLE_W:0] w_full;

    always_comb begin
        w_full = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
        // The two top bits disagree only when the true sum left the range.
        if (w_full[SAMPLE_W] != w_full[SAMPLE_W-1]) begin
            sum = w_full[SAMPLE_W] ? c_neg_min : c_pos_max;
        end else begin
            sum = w_full[SAMPLE_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dac_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dac_feed_ctrl
// Description : Per-slot two-source sample mixer with volume ramp and
//               underrun flag feeding the codec DAC path.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_feed_ctrl
    import dac_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RAMP_DIV    = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AUD_INIT_FINISH,
    input  logic        AUD_DATA_OVER,
    input  logic [31:0] SRC0_DATA,
    input  logic [31:0] SRC1_DATA,
    input  logic        SRC0_VALID,
    input  logic        SRC1_VALID,
    output logic        SRC0_READY,
    output logic        SRC1_READY,
    input  logic [7:0]  VOLUME_TARGET,
    input  logic        MUTE,
    input  logic        UNDERRUN_CLR,
    output logic [31:0] OUTPUT_DATA,
    output logic [7:0]  VOLUME_OUT,
    output logic        UNDERRUN
);

    localparam int c_cnt_w = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RAMP_DIV - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_slot_edge;
    feed_state_t            r_state;
    feed_state_t            w_state_nxt;
    logic                   w_fetch;
    logic [31:0]            w_mixed;
    logic [31:0]            w_fetch_data;
    logic [31:0]            r_out;
    logic                   r_underrun;
    logic [7:0]             w_target;
    logic [7:0]             r_target_prev;
    logic [7:0]             r_volume;
    logic [c_cnt_w-1:0]     r_slot_cnt;

    assign w_slot_edge = r_sync[SYNC_STAGES-1] & ~r_sync_d;
    assign w_fetch     = (r_state == ST_FETCH);
    assign w_target    = ramp_target(MUTE, VOLUME_TARGET);
    assign OUTPUT_DATA = r_out;
    assign VOLUME_OUT  = r_volume;
    assign UNDERRUN    = r_underrun;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_state  <= ST_IDLE;
        end else begin
            r_sync[0] <= AUD_DATA_OVER;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_sync_d <= r_sync[SYNC_STAGES-1];
            r_state  <= w_state_nxt;
        end
    end

    // Edges seen outside WAIT_SLOT are dropped, never queued.
    always_comb begin
        w_state_nxt = r_state;
        SRC0_READY  = 1'b0;
        SRC1_READY  = 1'b0;
        if (w_fetch) begin
            SRC0_READY = SRC0_VALID;
            SRC1_READY = SRC1_VALID;
        end
        if (!AUD_INIT_FINISH) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_nxt = ST_WAIT_SLOT;
                ST_WAIT_SLOT: if (w_slot_edge) w_state_nxt = ST_FETCH;
                ST_FETCH:     w_state_nxt = ST_WAIT_SLOT;
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        sample_mix u_mix (
            .a   (SRC0_DATA[ch*SAMPLE_W +: SAMPLE_W]),
            .b   (SRC1_DATA[ch*SAMPLE_W +: SAMPLE_W]),
            .sum (w_mixed[ch*SAMPLE_W +: SAMPLE_W])
        );
    end

    always_comb begin
        w_fetch_data = 32'd0;
        if (SRC0_VALID && SRC1_VALID) begin
            w_fetch_data = w_mixed;
        end else if (SRC0_VALID) begin
            w_fetch_data = SRC0_DATA;
        end else if (SRC1_VALID) begin
            w_fetch_data = SRC1_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_out      <= 32'd0;
            r_underrun <= 1'b0;
        end else begin
            if (!AUD_INIT_FINISH) begin
                r_out <= 32'd0;
            end else if (w_fetch) begin
                r_out <= w_fetch_data;
            end
            if (w_fetch && !SRC0_VALID && !SRC1_VALID) begin
                r_underrun <= 1'b1;
            end else if (UNDERRUN_CLR) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // A fresh target restarts the slot count so every step spans RAMP_DIV slots.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_target_prev <= 8'd0;
            r_slot_cnt    <= '0;
            r_volume      <= 8'd0;
        end else begin
            r_target_prev <= w_target;
            if (w_target != r_target_prev) begin
                r_slot_cnt <= '0;
            end else if (w_fetch) begin
                if (r_slot_cnt == c_cnt_last) begin
                    r_slot_cnt <= '0;
                    if (r_volume < w_target) begin
                        r_volume <= r_volume + 8'd1;
                    end else if (r_volume > w_target) begin
                        r_volume <= r_volume - 8'd1;
                    end
                end else begin
                    r_slot_cnt <= r_slot_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_feed_ctrl
// Description : Randomized slot-level bench for dac_feed_ctrl with a
//               behavioural mixer / ramp / underrun reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_feed_ctrl;

    localparam int RAMP = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        AUD_INIT_FINISH = 1'b0;
    logic        AUD_DATA_OVER = 1'b0;
    logic [31:0] SRC0_DATA = 32'd0;
    logic [31:0] SRC1_DATA = 32'd0;
    logic        SRC0_VALID = 1'b0;
    logic        SRC1_VALID = 1'b0;
    logic        SRC0_READY;
    logic        SRC1_READY;
    logic [7:0]  VOLUME_TARGET = 8'd0;
    logic        MUTE = 1'b0;
    logic        UNDERRUN_CLR = 1'b0;
    logic [31:0] OUTPUT_DATA;
    logic [7:0]  VOLUME_OUT;
    logic        UNDERRUN;

    dac_feed_ctrl #(.SYNC_STAGES(2), .RAMP_DIV(RAMP)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .AUD_INIT_FINISH (AUD_INIT_FINISH),
        .AUD_DATA_OVER   (AUD_DATA_OVER),
        .SRC0_DATA       (SRC0_DATA),
        .SRC1_DATA       (SRC1_DATA),
        .SRC0_VALID      (SRC0_VALID),
        .SRC1_VALID      (SRC1_VALID),
        .SRC0_READY      (SRC0_READY),
        .SRC1_READY      (SRC1_READY),
        .VOLUME_TARGET   (VOLUME_TARGET),
        .MUTE            (MUTE),
        .UNDERRUN_CLR    (UNDERRUN_CLR),
        .OUTPUT_DATA     (OUTPUT_DATA),
        .VOLUME_OUT      (VOLUME_OUT),
        .UNDERRUN        (UNDERRUN)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy0_cnt = 0;
    int rdy1_cnt = 0;

    logic [31:0] m_out = 32'd0;
    logic        m_und = 1'b0;
    int          m_vol = 0;
    int          m_cnt = 0;
    int          m_tgt_prev = 0;

    always @(negedge CLK) begin
        if (SRC0_READY === 1'b1) rdy0_cnt++;
        if (SRC1_READY === 1'b1) rdy1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        int c;
        c = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
        return c[15:0];
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] a, input logic [31:0] b);
        int l;
        int r;
        l = int'($signed(a[31:16])) + int'($signed(b[31:16]));
        r = int'($signed(a[15:0])) + int'($signed(b[15:0]));
        return {sat16(l), sat16(r)};
    endfunction

    function automatic int cur_target();
        if (MUTE) return 0;
        return (int'(VOLUME_TARGET) > 80) ? 80 : int'(VOLUME_TARGET);
    endfunction

    // One codec slot: strobe, check hold before the update, then the result.
    task automatic run_slot(input bit v0, input bit v1, input logic [31:0] d0,
                            input logic [31:0] d1, input bit clr, input bit active);
        int tgt;
        SRC0_VALID = v0;
        SRC1_VALID = v1;
        SRC0_DATA  = d0;
        SRC1_DATA  = d1;
        tgt = cur_target();
        if (tgt != m_tgt_prev) m_cnt = 0;
        m_tgt_prev = tgt;
        rdy0_cnt = 0;
        rdy1_cnt = 0;
        @(posedge CLK);
        #(1 + $urandom_range(0, 3));
        AUD_DATA_OVER = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        if (clr) UNDERRUN_CLR = 1'b1;
        check("out_hold", OUTPUT_DATA, m_out);
        @(posedge CLK);
        #1;
        UNDERRUN_CLR  = 1'b0;
        AUD_DATA_OVER = 1'b0;
        if (active) begin
            if (v0 && v1)  m_out = mix(d0, d1);
            else if (v0)   m_out = d0;
            else if (v1)   m_out = d1;
            else           m_out = 32'd0;
            m_cnt++;
            if (m_cnt == RAMP) begin
                m_cnt = 0;
                if (m_vol < tgt)      m_vol++;
                else if (m_vol > tgt) m_vol--;
            end
        end else begin
            m_out = 32'd0;
        end
        if (active && !v0 && !v1) m_und = 1'b1;
        else if (clr)             m_und = 1'b0;
        check("out_data", OUTPUT_DATA, m_out);
        check("underrun", {31'd0, UNDERRUN}, {31'd0, m_und});
        check("volume", {24'd0, VOLUME_OUT}, 32'(m_vol));
        repeat (5) @(posedge CLK);
        #1;
        check("ready0_pulses", 32'(rdy0_cnt), 32'(active && v0));
        check("ready1_pulses", 32'(rdy1_cnt), 32'(active && v1));
    endtask

    task automatic rand_slot(input bit active);
        bit v0;
        bit v1;
        v0 = ($urandom_range(0, 3) != 0);
        v1 = ($urandom_range(0, 3) != 0);
        run_slot(v0, v1, $urandom, $urandom, ($urandom_range(0, 5) == 0), active);
    endtask

    task automatic pulse_clr();
        UNDERRUN_CLR = 1'b1;
        @(posedge CLK);
        #1;
        UNDERRUN_CLR = 1'b0;
        m_und = 1'b0;
        check("underrun_clr", {31'd0, UNDERRUN}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out", OUTPUT_DATA, 32'd0);
        check("rst_vol", {24'd0, VOLUME_OUT}, 32'd0);
        check("rst_und", {31'd0, UNDERRUN}, 32'd0);
        check("rst_rdy", {30'd0, SRC1_READY, SRC0_READY}, 32'd0);
        RESET = 1'b0;
        AUD_INIT_FINISH = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        run_slot(1, 1, 32'h7000_0100, 32'h2000_FF00, 0, 1);
        check("both_valid_const", OUTPUT_DATA, 32'h7FFF_0000);
        run_slot(0, 1, 32'hDEAD_BEEF, 32'h1234_ABCD, 0, 1);
        check("src1_only_const", OUTPUT_DATA, 32'h1234_ABCD);
        run_slot(0, 0, $urandom, $urandom, 0, 1);
        run_slot(0, 0, $urandom, $urandom, 1, 1);
        check("set_wins_const", {31'd0, UNDERRUN}, 32'd1);
        pulse_clr();
        run_slot(1, 1, 32'h8000_8000, 32'hFFFF_8000, 0, 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                VOLUME_TARGET = 8'($urandom_range(0, 255));
                MUTE = ($urandom_range(0, 4) == 0);
            end
            rand_slot(1);
        end

        // Reset landing inside FETCH.
        SRC0_VALID = 1'b1;
        SRC1_VALID = 1'b1;
        @(posedge CLK);
        #2;
        AUD_DATA_OVER = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("fetch_ready", {31'd0, SRC0_READY}, 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("rst_fetch_rdy", {30'd0, SRC1_READY, SRC0_READY}, 32'd0);
        check("rst_fetch_out", OUTPUT_DATA, 32'd0);
        check("rst_fetch_vol", {24'd0, VOLUME_OUT}, 32'd0);
        check("rst_fetch_und", {31'd0, UNDERRUN}, 32'd0);
        AUD_DATA_OVER = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        m_out = 32'd0;
        m_und = 1'b0;
        m_vol = 0;
        m_cnt = 0;
        m_tgt_prev = cur_target();
        repeat (2) @(posedge CLK);
        #1;

        VOLUME_TARGET = 8'd200;
        MUTE = 1'b0;
        for (int i = 0; i < 330; i++) rand_slot(1);
        check("ramp_top", {24'd0, VOLUME_OUT}, 32'd80);
        MUTE = 1'b1;
        for (int i = 0; i < 330; i++) rand_slot(1);
        check("ramp_bottom", {24'd0, VOLUME_OUT}, 32'd0);
        MUTE = 1'b0;
        VOLUME_TARGET = 8'd30;
        for (int i = 0; i < 20; i++) rand_slot(1);

        // Codec init dropped: idle, output cleared, no handshakes.
        AUD_INIT_FINISH = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        m_out = 32'd0;
        check("init_low_out", OUTPUT_DATA, 32'd0);
        check("init_low_vol", {24'd0, VOLUME_OUT}, 32'(m_vol));
        for (int i = 0; i < 3; i++) run_slot(1, 1, $urandom, $urandom, 0, 0);
        AUD_INIT_FINISH = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 30; i++) rand_slot(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_feed_ctrl.md
DAC_FEED_CTRL -- requirements
Module: dac_feed_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for AUD_DATA_OVER.
REQ-002 SHALL have parameter RAMP_DIV, default 16, meaning sample slots per one-step volume change (>=1).
REQ-003 SHALL have port CLK  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port AUD_INIT_FINISH  in  1  codec init done (level).
REQ-006 SHALL have port AUD_DATA_OVER  in  1  codec sample-slot strobe, asynchronous to CLK.
REQ-007 SHALL have ports SRC0_DATA, SRC1_DATA  in  32  stereo samples, [31:16] left, [15:0] right, signed.
REQ-008 SHALL have ports SRC0_VALID, SRC1_VALID  in  1  sample offered.
REQ-009 SHALL have ports SRC0_READY, SRC1_READY  out  1  sample accepted this cycle.
REQ-010 SHALL have port VOLUME_TARGET  in  8  requested volume, 0..80.
REQ-011 SHALL have port MUTE  in  1  force ramp target to 0.
REQ-012 SHALL have port UNDERRUN_CLR  in  1  clears UNDERRUN.
REQ-013 SHALL have port OUTPUT_DATA  out  32  mixed sample to the DAC path.
REQ-014 SHALL have port VOLUME_OUT  out  8  current ramped volume to the DAC path.
REQ-015 SHALL have port UNDERRUN  out  1  sticky: a slot had no valid source.

Function
REQ-016 SHALL pass AUD_DATA_OVER through SYNC_STAGES flops, then a rising-edge detector; one detected edge = one slot.
REQ-017 SHALL implement FSM IDLE, WAIT_SLOT, FETCH; IDLE->WAIT_SLOT when AUD_INIT_FINISH=1; WAIT_SLOT->FETCH on detected edge; FETCH->WAIT_SLOT unconditionally.
REQ-018 SHALL, from any state, go to IDLE in the cycle after AUD_INIT_FINISH=0, clear OUTPUT_DATA to 0, and hold VOLUME_OUT.
REQ-019 SHALL in FETCH assert SRCn_READY for exactly that one cycle iff SRCn_VALID=1; READY=0 in all other states.
REQ-020 SHALL, when both sources are valid in FETCH, load OUTPUT_DATA with the per-channel signed 16-bit sum saturated to [-32768, 32767].
REQ-021 SHALL, when exactly one source is valid, load OUTPUT_DATA with that source's sample unchanged.
REQ-022 SHALL, when neither source is valid, load OUTPUT_DATA with 0 and set UNDERRUN.
REQ-023 SHALL update OUTPUT_DATA on the clock edge ending FETCH: edge detected in cycle N -> FETCH in N+1 -> new OUTPUT_DATA visible from N+2.
REQ-024 SHALL ignore detected edges while in IDLE or FETCH (no queued slots); AUD_DATA_OVER period is at least 8 CLK.
REQ-025 SHALL clamp the ramp target to 80 (target = 0 if MUTE, else min(VOLUME_TARGET, 80)).
REQ-026 SHALL count FETCH slots modulo RAMP_DIV; on wrap, step VOLUME_OUT by 1 toward the target; no step when equal.
REQ-027 SHALL restart the slot counter at 0 whenever the target changes value.
REQ-028 SHALL, when UNDERRUN_CLR and a new underrun coincide, leave UNDERRUN=1 (set wins).

Reset
REQ-029 SHALL on RESET=1 immediately force state=IDLE, OUTPUT_DATA=0, VOLUME_OUT=0, SRCn_READY=0, UNDERRUN=0, synchronizer, edge detector and slot counter to 0.
REQ-030 SHALL abort a FETCH interrupted by reset with no handshake completed.

Structure
REQ-031 SHALL take VOLUME_MAX (80), the FSM state enum and the sample width (16) from shared package dac_pkg.
REQ-032 SHALL instantiate one sub-module sample_mix (two signed 16-bit inputs, saturating sum), used once per channel.

Verification
REQ-033 Both valid, SRC0=0x7000_0100, SRC1=0x2000_FF00, one slot -> OUTPUT_DATA=0x7FFF_0000, both READY pulse once.
REQ-034 Only SRC1 valid = 0x1234_ABCD -> OUTPUT_DATA=0x1234_ABCD, SRC0_READY stays 0, UNDERRUN=0.
REQ-035 No source valid for one slot -> OUTPUT_DATA=0, UNDERRUN=1 until UNDERRUN_CLR; held 1 if clear coincides with underrun.
REQ-036 RAMP_DIV=4, VOLUME_TARGET=200 from VOLUME_OUT=0 -> VOLUME_OUT +1 every 4 slots, stops at 80; MUTE -> decrements to 0.
REQ-037 RESET asserted in FETCH -> all outputs reset values same cycle; AUD_INIT_FINISH=0 -> IDLE, no READY on later strobes.
